// File: rtl/tinyyolo_pkg.sv
// Shared types and helpers for the TinyYOLO output-path blocks.
// Carries the result-sink state encoding and the data-signature fold.
package tinyyolo_pkg;

   localparam int SIG_WIDTH      = 32;
   // Widest stream the fold accepts; callers zero-extend, and zero lanes leave the XOR unchanged.
   localparam int FOLD_MAX_WIDTH = 4096;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } sink_state_t;

   function automatic logic [SIG_WIDTH-1:0] fold32(input logic [FOLD_MAX_WIDTH-1:0] data);
      logic [SIG_WIDTH-1:0] acc;
      acc = '0;
      for (int i = 0; i < FOLD_MAX_WIDTH / SIG_WIDTH; i++) begin
         acc ^= data[i*SIG_WIDTH +: SIG_WIDTH];
      end
      return acc;
   endfunction

endpackage

// File: rtl/tinyyolo_axis_result_sink.sv
// AXI4-Stream result sink: counts beats against a latched frame length,
// checks tlast placement, signs the data and pulses ap_done at frame end.
//
// state | meaning
// IDLE  | tready low, waiting for ap_start
// RUN   | tready high, accepting beats until tlast or expected count
// DONE  | tready low, ap_done high for one cycle
module tinyyolo_axis_result_sink
   import tinyyolo_pkg::*;
#(
   parameter int C_AXIS_TDATA_WIDTH = 512,
   parameter int C_BEAT_COUNT_WIDTH = 32
) (
   input  logic                          aclk,
   input  logic                          areset,
   input  logic                          ap_start,
   input  logic [C_BEAT_COUNT_WIDTH-1:0] expected_beats,
   input  logic                          s_axis_tvalid,
   output logic                          s_axis_tready,
   input  logic [C_AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
   input  logic                          s_axis_tlast,
   output logic                          ap_done,
   output logic                          busy,
   output logic [C_BEAT_COUNT_WIDTH-1:0] beat_count,
   output logic [SIG_WIDTH-1:0]          signature,
   output logic                          err_early_last,
   output logic                          err_missing_last
);

   sink_state_t                   state;
   sink_state_t                   state_nxt;
   logic [C_BEAT_COUNT_WIDTH-1:0] exp_beats;
   logic [C_BEAT_COUNT_WIDTH-1:0] beat_n;
   logic [FOLD_MAX_WIDTH-1:0]     tdata_ext;
   logic                          accept;
   logic                          start_ok;

   // Handshake outputs decode the state register only, so tready never depends on tvalid.
   assign s_axis_tready = (state == RUN);
   assign ap_done       = (state == DONE);
   assign busy          = (state != IDLE);

   assign accept    = s_axis_tvalid & s_axis_tready;
   assign start_ok  = (state == IDLE) & ap_start;
   assign beat_n    = beat_count + C_BEAT_COUNT_WIDTH'(1);
   assign tdata_ext = FOLD_MAX_WIDTH'(s_axis_tdata);

   always_ff @(posedge aclk) begin
      if (areset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (ap_start) begin
               state_nxt = (expected_beats == '0) ? DONE : RUN;
            end
         end
         RUN: begin
            if (accept && (s_axis_tlast || (beat_n == exp_beats))) begin
               state_nxt = DONE;
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         exp_beats        <= '0;
         beat_count       <= '0;
         signature        <= '0;
         err_early_last   <= 1'b0;
         err_missing_last <= 1'b0;
      end else if (start_ok) begin
         exp_beats        <= expected_beats;
         beat_count       <= '0;
         signature        <= '0;
         err_early_last   <= 1'b0;
         err_missing_last <= 1'b0;
      end else if (accept) begin
         beat_count <= beat_n;
         signature  <= {signature[SIG_WIDTH-2:0], signature[SIG_WIDTH-1]} ^ fold32(tdata_ext);
         if (s_axis_tlast && (beat_n < exp_beats)) begin
            err_early_last <= 1'b1;
         end
         if (!s_axis_tlast && (beat_n == exp_beats)) begin
            err_missing_last <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_tinyyolo_axis_result_sink.sv
// Scoreboard bench for the result sink: per-frame expected results are queued
// at start and checked when ap_done fires.
module tb_tinyyolo_axis_result_sink;

   localparam int DW    = 512;
   localparam int CW    = 32;
   localparam int LANES = DW / 32;

   logic          aclk = 1'b0;
   logic          areset;
   logic          ap_start;
   logic [CW-1:0] expected_beats;
   logic          s_axis_tvalid;
   logic          s_axis_tready;
   logic [DW-1:0] s_axis_tdata;
   logic          s_axis_tlast;
   logic          ap_done;
   logic          busy;
   logic [CW-1:0] beat_count;
   logic [31:0]   signature;
   logic          err_early_last;
   logic          err_missing_last;

   typedef struct packed {
      logic [31:0] cnt;
      logic [31:0] sig;
      logic        early;
      logic        missing;
   } res_t;

   res_t sb_q[$];
   int   total     = 0;
   int   bad       = 0;
   int   done_seen = 0;

   tinyyolo_axis_result_sink #(
      .C_AXIS_TDATA_WIDTH(DW),
      .C_BEAT_COUNT_WIDTH(CW)
   ) dut (
      .aclk            (aclk),
      .areset          (areset),
      .ap_start        (ap_start),
      .expected_beats  (expected_beats),
      .s_axis_tvalid   (s_axis_tvalid),
      .s_axis_tready   (s_axis_tready),
      .s_axis_tdata    (s_axis_tdata),
      .s_axis_tlast    (s_axis_tlast),
      .ap_done         (ap_done),
      .busy            (busy),
      .beat_count      (beat_count),
      .signature       (signature),
      .err_early_last  (err_early_last),
      .err_missing_last(err_missing_last)
   );

   always #5 aclk = ~aclk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h want=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [DW-1:0] make_beat(input int mode, input int idx);
      logic [DW-1:0] d;
      d = '0;
      for (int l = 0; l < LANES; l++) begin
         if (mode == 0) d[l*32 +: 32] = 32'(idx + 1);
      end
      if (mode == 1) d[31:0] = 32'(idx);
      return d;
   endfunction

   function automatic logic [31:0] ref_fold(input logic [DW-1:0] d);
      logic [31:0] f;
      f = '0;
      for (int l = 0; l < LANES; l++) f ^= d[l*32 +: 32];
      return f;
   endfunction

   always @(negedge aclk) begin
      if (!areset && ap_done) begin
         res_t r;
         done_seen++;
         if (sb_q.size() == 0) begin
            chk("done_unexpected", 64'd1, 64'd0);
         end else begin
            r = sb_q.pop_front();
            chk("sb_count", 64'(beat_count), 64'(r.cnt));
            chk("sb_sig", 64'(signature), 64'(r.sig));
            chk("sb_early", 64'(err_early_last), 64'(r.early));
            chk("sb_missing", 64'(err_missing_last), 64'(r.missing));
            chk("sb_busy", 64'(busy), 64'd1);
         end
      end
   end

   task automatic drive_frame(input string name, input int e, input int n_beats, input int last_idx,
                              input int gap_pct, input int mode, input int max_cyc);
      res_t        r;
      int          term_idx;
      int          exp_acc;
      int          accepted;
      int          cyc;
      int          done0;
      bit          push;
      bit          done_chk;
      bit          v;
      logic [31:0] s;

      term_idx = -1;
      s        = '0;
      r        = '0;
      for (int i = 0; i < n_beats && e != 0; i++) begin
         s = {s[30:0], s[31]} ^ ref_fold(make_beat(mode, i));
         if (i == last_idx || i + 1 == e) begin
            term_idx  = i;
            r.early   = (i == last_idx) && (i + 1 < e);
            r.missing = (i != last_idx) && (i + 1 == e);
            break;
         end
      end
      r.cnt   = (term_idx >= 0) ? 32'(term_idx + 1) : 32'd0;
      r.sig   = (term_idx >= 0) ? s : 32'd0;
      push    = (e == 0) || (term_idx >= 0);
      exp_acc = (e == 0) ? 0 : ((term_idx >= 0) ? term_idx + 1 : n_beats);
      if (push) sb_q.push_back(r);
      done0 = done_seen;

      @(negedge aclk);
      ap_start       = 1'b1;
      expected_beats = CW'(e);
      @(negedge aclk);
      ap_start = 1'b0;
      chk({name, "_tready_start"}, 64'(s_axis_tready), 64'(e != 0));
      if (e == 0) chk({name, "_done_e0"}, 64'(ap_done), 64'd1);

      accepted = 0;
      cyc      = 0;
      done_chk = 1'b0;
      while (accepted < n_beats && cyc < max_cyc) begin
         if (done_chk) begin
            chk({name, "_done_pulse"}, 64'(ap_done), 64'd1);
            chk({name, "_tready_end"}, 64'(s_axis_tready), 64'd0);
            done_chk = 1'b0;
         end
         v             = ($urandom_range(99) >= gap_pct);
         s_axis_tvalid = v;
         s_axis_tdata  = make_beat(mode, accepted);
         s_axis_tlast  = (accepted == last_idx);
         if (v && s_axis_tready) begin
            if (accepted == term_idx) done_chk = 1'b1;
            accepted++;
         end
         @(negedge aclk);
         cyc++;
      end
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
      if (done_chk) begin
         chk({name, "_done_pulse"}, 64'(ap_done), 64'd1);
         chk({name, "_tready_end"}, 64'(s_axis_tready), 64'd0);
      end
      chk({name, "_accepted"}, 64'(accepted), 64'(exp_acc));
      if (push) begin
         @(negedge aclk);
         chk({name, "_idle"}, 64'(busy), 64'd0);
         chk({name, "_done_once"}, 64'(done_seen - done0), 64'd1);
      end
   endtask

   initial begin
      int done_before;
      areset         = 1'b1;
      ap_start       = 1'b0;
      expected_beats = '0;
      s_axis_tvalid  = 1'b0;
      s_axis_tdata   = '0;
      s_axis_tlast   = 1'b0;
      repeat (3) @(negedge aclk);
      chk("rst_tready", 64'(s_axis_tready), 64'd0);
      chk("rst_done", 64'(ap_done), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_count", 64'(beat_count), 64'd0);
      chk("rst_sig", 64'(signature), 64'd0);
      chk("rst_errs", 64'({err_early_last, err_missing_last}), 64'd0);
      areset = 1'b0;
      @(negedge aclk);

      drive_frame("e4", 4, 4, 3, 0, 0, 20);
      drive_frame("e8gap", 8, 8, 7, 40, 1, 200);
      drive_frame("early", 5, 5, 2, 0, 1, 12);
      drive_frame("missing", 3, 5, -1, 0, 1, 12);
      drive_frame("e0", 0, 2, -1, 0, 1, 4);

      done_before = done_seen;
      drive_frame("abort", 6, 2, -1, 0, 1, 50);
      areset = 1'b1;
      @(negedge aclk);
      chk("abort_tready", 64'(s_axis_tready), 64'd0);
      chk("abort_done", 64'(ap_done), 64'd0);
      chk("abort_busy", 64'(busy), 64'd0);
      chk("abort_count", 64'(beat_count), 64'd0);
      chk("abort_sig", 64'(signature), 64'd0);
      chk("abort_errs", 64'({err_early_last, err_missing_last}), 64'd0);
      areset = 1'b0;
      @(negedge aclk);
      chk("abort_no_done", 64'(done_seen - done_before), 64'd0);

      drive_frame("e2", 2, 2, 1, 0, 0, 20);
      chk("sb_drained", 64'(sb_q.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/tinyyolo_axis_result_sink.md
# tinyyolo_axis_result_sink

Stream-receiving end of the TinyYOLO kernel output path: consumes the AXI4-Stream produced by the compute unit, counts accepted beats against an expected length latched at `ap_start`, checks `tlast` placement, accumulates a 32-bit signature of the data, and emits a one-cycle `ap_done`. Used as the on-chip sink in hardware self-test builds and as the reusable result checker in kernel-level benches.

## Interface
Parameters:
- `C_AXIS_TDATA_WIDTH`, 512, stream data width; multiple of 32.
- `C_BEAT_COUNT_WIDTH`, 32, width of beat counter and expected-length input.

Ports:
- `aclk`  in  1  kernel clock.
- `areset`  in  1  reset, synchronous, active-high.
- `ap_start`  in  1  start pulse; sampled only in IDLE.
- `expected_beats`  in  C_BEAT_COUNT_WIDTH  beats in the frame; latched on accepted start.
- `s_axis_tvalid`  in  1  stream valid.
- `s_axis_tready`  out  1  stream ready.
- `s_axis_tdata`  in  C_AXIS_TDATA_WIDTH  stream data.
- `s_axis_tlast`  in  1  last beat of frame.
- `ap_done`  out  1  one-cycle completion pulse.
- `busy`  out  1  high in RUN and DONE.
- `beat_count`  out  C_BEAT_COUNT_WIDTH  beats accepted in current/last frame.
- `signature`  out  32  data signature of current/last frame.
- `err_early_last`  out  1  `tlast` seen before expected count.
- `err_missing_last`  out  1  expected count reached without `tlast`.

## Operation
- States: IDLE, RUN, DONE.
- IDLE: `tready`=0. On `ap_start`: latch `expected_beats`, clear `beat_count`, `signature`, both error flags. Next state RUN, or DONE if `expected_beats`==0.
- RUN: `tready`=1. Beat accepted when `tvalid & tready`. Per beat: `beat_count`+=1; `signature` = rotl(`signature`,1) XOR fold(`tdata`), fold = XOR of all 32-bit lanes.
- Termination on accepted beat with n = `beat_count`+1 and E = latched expected:
  - `tlast` & n==E: DONE, no error.
  - `tlast` & n<E: set `err_early_last`, DONE.
  - !`tlast` & n==E: set `err_missing_last`, DONE.
  - otherwise stay RUN.
- DONE: `tready`=0, `ap_done`=1 for exactly one cycle, then IDLE.
- `ap_start` in RUN/DONE ignored. `beat_count`, `signature`, error flags hold from DONE until next accepted `ap_start`.
- Counter arithmetic modulo 2^C_BEAT_COUNT_WIDTH; n compared at full width; no saturation.

## Timing
- Reset values: `s_axis_tready`=0, `ap_done`=0, `busy`=0, `beat_count`=0, `signature`=0, both errors 0; state IDLE.
- `ap_start` at cycle t -> `tready`=1 at t+1 (E≠0); first beat may be accepted at t+1.
- Full throughput: one beat per cycle while `tvalid` held.
- Terminating beat at cycle t -> `tready`=0 and `ap_done`=1 at t+1; IDLE at t+2; new `ap_start` accepted at t+2.
- E==0: `ap_done` at t+1, no beats accepted.
- `tready` driven from a state register; no combinational path from `tvalid`/`tlast`.
- `areset` mid-frame: return to IDLE next cycle, all outputs to reset values, no `ap_done`.
- `tvalid` low cycles in RUN: no state change.

## Structure
- Shared package `tinyyolo_pkg`: state enum `sink_state_t` (IDLE/RUN/DONE), function `fold32` (XOR-fold of a C_AXIS_TDATA_WIDTH vector to 32 bits), constant `SIG_WIDTH`=32.
- No sub-modules; single flat module.

## Test plan
- Reset, then `ap_start` with E=4, four beats tdata = {16{32'h1}}..{16{32'h4}} back-to-back, `tlast` on 4th -> `ap_done` one cycle after 4th beat, `beat_count`=4, no errors, `signature` matches model (fold of each = 0).
- E=8, tdata lane0 = beat index else 0, random `tvalid` gaps -> `beat_count`=8, `signature` = model rotl/XOR of 0..7, `ap_done` exactly once.
- E=5, `tlast` on beat 3 -> `err_early_last`=1, `beat_count`=3, `tready` low next cycle.
- E=3, no `tlast` -> `err_missing_last`=1 after beat 3, beats 4+ not accepted.
- E=0 -> `ap_done` at t+1, `tready` never high, `beat_count`=0.
- `areset` after beat 2 of E=6 -> all outputs zero next cycle, no `ap_done`; new `ap_start` with E=2 completes cleanly.
